// File: rtl/arbitro_contador.sv
// arbitro_contador: round-robin scheduler that shares one zera/conta/registra
// measurement datapath among N_REQ requesters. Each granted requester gets one
// full measurement (ZERA, CONTA until fim_contador, REGISTRA, FIM), and
// ptr rotates so the search after a grant starts just past the last winner.
// Optional feature macro: ARBITRO_TIMEOUT_EN aborts CONTA after TIMEOUT cycles
// without fim_contador, skipping REGISTRA and pulsing erro together with pronto.
module arbitro_contador #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic                       fim_contador,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   id_grant,
    output logic                       zera,
    output logic                       conta,
    output logic                       registra,
    output logic                       pronto,
    output logic                       ocupado,
    output logic                       erro
);

    localparam int unsigned IDW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ZERA     = 3'd1,
        CONTA    = 3'd2,
        REGISTRA = 3'd3,
        FIM      = 3'd4
    } estado_t;

    estado_t            state_r;
    estado_t            state_s;
    logic [N_REQ-1:0]   grant_r;
    logic [IDW-1:0]     id_r;
    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     winner_s;
    logic [N_REQ-1:0]   onehot_s;
    logic               timeout_hit_s;
    logic               zera_s;
    logic               conta_s;
    logic               registra_s;
    logic               pronto_s;
    logic               ocupado_s;

    // First set bit of r, searching from (p+1) mod N_REQ upward with wrap.
    function automatic logic [IDW-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                   input logic [IDW-1:0]   p);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = '0;
        found = 1'b0;
        for (int off = 1; off <= int'(N_REQ); off++) begin
            idx = (int'(p) + off) % int'(N_REQ);
            if (!found && r[idx[IDW-1:0]]) begin
                w     = idx[IDW-1:0];
                found = 1'b1;
            end else begin
                w     = w;
            end
        end
        return w;
    endfunction

    // Winner index and its one-hot form, evaluated against the current pointer.
    always_comb begin
        winner_s           = pick_winner(req, ptr_r);
        onehot_s           = '0;
        onehot_s[winner_s] = 1'b1;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= OCIOSO;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; fim_contador is only looked at in CONTA and beats a timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            OCIOSO: begin
                if (|req) begin
                    state_s = ZERA;
                end else begin
                    state_s = OCIOSO;
                end
            end
            ZERA:     state_s = CONTA;
            CONTA: begin
                if (fim_contador) begin
                    state_s = REGISTRA;
                end else if (timeout_hit_s) begin
                    state_s = FIM;
                end else begin
                    state_s = CONTA;
                end
            end
            REGISTRA: state_s = FIM;
            FIM:      state_s = OCIOSO;
            default:  state_s = OCIOSO;
        endcase
    end

    // Moore output decode from the registered state only.
    always_comb begin
        zera_s     = 1'b0;
        conta_s    = 1'b0;
        registra_s = 1'b0;
        pronto_s   = 1'b0;
        ocupado_s  = 1'b1;
        case (state_r)
            OCIOSO:   ocupado_s  = 1'b0;
            ZERA:     zera_s     = 1'b1;
            CONTA:    conta_s    = 1'b1;
            REGISTRA: registra_s = 1'b1;
            FIM:      pronto_s   = 1'b1;
            default:  ocupado_s  = 1'b0;
        endcase
    end

    // Grant capture in OCIOSO, release and pointer rotation when leaving FIM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            grant_r <= '0;
            id_r    <= '0;
            ptr_r   <= IDW'(N_REQ - 1);
        end else begin
            case (state_r)
                OCIOSO: begin
                    if (|req) begin
                        grant_r <= onehot_s;
                        id_r    <= winner_s;
                    end else begin
                        grant_r <= grant_r;
                        id_r    <= id_r;
                    end
                end
                FIM: begin
                    ptr_r   <= id_r;
                    grant_r <= '0;
                    id_r    <= '0;
                end
                default: begin
                    grant_r <= grant_r;
                    id_r    <= id_r;
                end
            endcase
        end
    end

`ifdef ARBITRO_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] cnt_r;
    logic          erro_r;

    // CONTA cycle counter: cleared in ZERA so it starts at 0 in the first CONTA cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (state_r == ZERA) begin
            cnt_r <= '0;
        end else if (state_r == CONTA) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Hit in the TIMEOUT-th CONTA cycle.
    assign timeout_hit_s = (state_r == CONTA) && (cnt_r == CW'(TIMEOUT - 1));

    // Abort flag: high exactly during the FIM reached through a timeout.
    always_ff @(posedge clock) begin
        if (!reset) begin
            erro_r <= 1'b0;
        end else begin
            erro_r <= timeout_hit_s && !fim_contador;
        end
    end

    assign erro = erro_r;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (TIMEOUT > 0);
    assign timeout_hit_s    = 1'b0;
    assign erro             = 1'b0;
`endif

    assign grant    = grant_r;
    assign id_grant = id_r;
    assign zera     = zera_s;
    assign conta    = conta_s;
    assign registra = registra_s;
    assign pronto   = pronto_s;
    assign ocupado  = ocupado_s;

endmodule

// File: tb/tb_arbitro_contador.sv
// Self-checking bench for arbitro_contador: directed scenarios plus random
// stimulus, compared every cycle against a transaction-phase reference model.
module tb_arbitro_contador;

    localparam int N  = 4;
    localparam int TO = 10;
`ifdef ARBITRO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int P_IDLE = 0;
    localparam int P_ZERA = 1;
    localparam int P_CONT = 2;
    localparam int P_REG  = 3;
    localparam int P_DONE = 4;

    localparam int F_ALWAYS = 0;
    localparam int F_NEVER  = 1;
    localparam int F_AT     = 2;
    localparam int F_RAND   = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req = '0;
    logic         fim_contador = 1'b0;
    logic [N-1:0] grant;
    logic [1:0]   id_grant;
    logic         zera, conta, registra, pronto, ocupado, erro;

    arbitro_contador #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .req(req), .fim_contador(fim_contador),
        .grant(grant), .id_grant(id_grant), .zera(zera), .conta(conta),
        .registra(registra), .pronto(pronto), .ocupado(ocupado), .erro(erro)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model: which phase of a transaction we are in
    int m_phase = P_IDLE;
    int m_id    = 0;
    int m_ptr   = N - 1;
    int m_cnt   = 0;
    bit m_err   = 1'b0;

    int fim_mode = F_ALWAYS;
    int fim_at   = 1;

    int n_zera, n_conta, n_reg, n_pronto, n_erro;
    logic [N-1:0] last_grant;
    int ids[$];
    int pcyc[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_tally();
        n_zera = 0; n_conta = 0; n_reg = 0; n_pronto = 0; n_erro = 0;
        ids.delete();
        pcyc.delete();
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit found;
        int i;
        if (!reset) begin
            m_phase = P_IDLE; m_ptr = N - 1; m_cnt = 0; m_err = 1'b0; m_id = 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    found = 1'b0;
                    for (int off = 1; off <= N; off++) begin
                        i = (m_ptr + off) % N;
                        if (!found && req[i]) begin
                            m_id = i;
                            found = 1'b1;
                        end
                    end
                    if (found) m_phase = P_ZERA;
                end
                P_ZERA: begin
                    m_phase = P_CONT;
                    m_cnt = 0;
                end
                P_CONT: begin
                    m_cnt++;
                    if (fim_contador) m_phase = P_REG;
                    else if (TO_EN && m_cnt == TO) begin
                        m_phase = P_DONE;
                        m_err = 1'b1;
                    end
                end
                P_REG: m_phase = P_DONE;
                P_DONE: begin
                    m_ptr = m_id;
                    m_err = 1'b0;
                    m_phase = P_IDLE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    // One clock: model update, compare all outputs, tally, drive fim_contador.
    task automatic cycle();
        logic [N-1:0] eg;
        @(posedge clock);
        model_step();
        cyc++;
        #1;
        eg = '0;
        if (m_phase != P_IDLE) eg[m_id] = 1'b1;
        check_eq("grant",    32'(grant),    32'(eg));
        check_eq("id_grant", 32'(id_grant), (m_phase != P_IDLE) ? 32'(m_id) : 32'd0);
        check_eq("zera",     32'(zera),     32'(m_phase == P_ZERA));
        check_eq("conta",    32'(conta),    32'(m_phase == P_CONT));
        check_eq("registra", 32'(registra), 32'(m_phase == P_REG));
        check_eq("pronto",   32'(pronto),   32'(m_phase == P_DONE));
        check_eq("ocupado",  32'(ocupado),  32'(m_phase != P_IDLE));
        check_eq("erro",     32'(erro),     32'(m_phase == P_DONE && m_err));
        if (zera) n_zera++;
        if (conta) n_conta++;
        if (registra) n_reg++;
        if (erro) n_erro++;
        if (pronto) begin
            n_pronto++;
            ids.push_back(int'(id_grant));
            pcyc.push_back(cyc);
            last_grant = grant;
        end
        case (fim_mode)
            F_ALWAYS: fim_contador = 1'b1;
            F_NEVER:  fim_contador = 1'b0;
            F_AT:     fim_contador = (m_phase == P_CONT) && (m_cnt + 1 == fim_at);
            F_RAND:   fim_contador = ($urandom_range(0, 3) == 0);
            default:  fim_contador = 1'b0;
        endcase
    endtask

    task automatic run_until_pronto(input string tag, input int max);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < max) begin
            cycle();
            k++;
            if (pronto) seen = 1'b1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic run_until_conta(input string tag, input int max);
        int k;
        k = 0;
        while (m_phase != P_CONT && k < max) begin
            cycle();
            k++;
        end
        check_eq(tag, 32'(conta), 32'd1);
    endtask

    initial begin
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        clear_tally();

        // reset held with all requests active
        reset = 1'b0; req = 4'b1111; fim_mode = F_ALWAYS;
        repeat (3) cycle();
        check_eq("rst_ocupado", 32'(ocupado), 32'd0);

        // release: req[0] first, then strict rotation
        reset = 1'b1;
        cycle();
        check_eq("rst_first_grant", 32'(grant), 32'b0001);
        for (int t = 0; t < 5; t++) run_until_pronto("rr_done", 12);
        req = '0;
        for (int t = 0; t < 5; t++) check_eq("rr_order", 32'(ids[t]), 32'(exp_rr[t]));
        for (int t = 1; t < 5; t++) check_eq("rr_spacing", 32'(pcyc[t] - pcyc[t-1]), 32'd5);
        repeat (2) cycle();

        // single request, fim on the 5th CONTA cycle
        clear_tally();
        req = 4'b0100; fim_mode = F_AT; fim_at = 5;
        run_until_pronto("single_done", 20);
        req = '0;
        check_eq("single_zera", 32'(n_zera), 32'd1);
        check_eq("single_conta", 32'(n_conta), 32'd5);
        check_eq("single_reg", 32'(n_reg), 32'd1);
        check_eq("single_pronto", 32'(n_pronto), 32'd1);
        check_eq("single_grant", 32'(last_grant), 32'b0100);
        repeat (2) cycle();

        // request changes during CONTA are ignored until the next OCIOSO
        clear_tally();
        req = 4'b0010; fim_at = 3;
        run_until_conta("mid_conta", 6);
        req = 4'b1000;
        run_until_pronto("mid_done1", 12);
        check_eq("mid_grant1", 32'(last_grant), 32'b0010);
        run_until_pronto("mid_done2", 12);
        check_eq("mid_grant2", 32'(last_grant), 32'b1000);
        req = '0;
        repeat (2) cycle();

        // reset in the middle of CONTA abandons the transaction
        clear_tally();
        req = 4'b0100; fim_mode = F_NEVER;
        run_until_conta("rstmid_conta", 6);
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        check_eq("rstmid_pronto", 32'(n_pronto), 32'd0);
        check_eq("rstmid_grant", 32'(grant), 32'd0);
        reset = 1'b1; req = 4'b1111; fim_mode = F_ALWAYS;
        cycle();
        check_eq("rstmid_prio", 32'(grant), 32'b0001);
        req = '0;
        repeat (6) cycle();

        // timeout behaviour
        clear_tally();
        req = 4'b0001; fim_mode = F_NEVER;
`ifdef ARBITRO_TIMEOUT_EN
        run_until_pronto("to_done", 20);
        check_eq("to_conta", 32'(n_conta), 32'd10);
        check_eq("to_erro", 32'(n_erro), 32'd1);
        check_eq("to_reg", 32'(n_reg), 32'd0);
        clear_tally();
        fim_mode = F_AT; fim_at = 10;
        run_until_pronto("to_fim_done", 20);
        check_eq("to_fim_conta", 32'(n_conta), 32'd10);
        check_eq("to_fim_reg", 32'(n_reg), 32'd1);
        check_eq("to_fim_erro", 32'(n_erro), 32'd0);
`else
        repeat (40) cycle();
        check_eq("noto_pronto", 32'(n_pronto), 32'd0);
        check_eq("noto_conta", 32'(n_conta), 32'd39);
        fim_mode = F_ALWAYS;
        run_until_pronto("noto_done", 6);
        check_eq("noto_erro", 32'(n_erro), 32'd0);
`endif
        req = '0;
        repeat (2) cycle();

        // random traffic with occasional resets
        fim_mode = F_RAND;
        for (int t = 0; t < 600; t++) begin
            req = N'($urandom_range(0, 15));
            reset = ($urandom_range(0, 99) != 0);
            cycle();
        end
        reset = 1'b1;
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/arbitro_contador.md
# arbitro_contador

- Round-robin scheduler that shares the single counter/register measurement datapath (zera → conta until fim_contador → registra) among N_REQ requesters.
- Accepts one requester per transaction, sequences the datapath through one full measurement, then signals completion to the granted requester.
- Sits between the requesting units and the counter/register datapath, in place of a single-user control unit.

## Interface

Parameters:
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 255, max cycles in CONTA before abort (used only with ARBITRO_TIMEOUT_EN)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- req  input  N_REQ  per-requester measurement request, level, held until pronto
- fim_contador  input  1  datapath count-complete flag
- grant  output  N_REQ  one-hot grant, held for the whole transaction
- id_grant  output  $clog2(N_REQ)  binary index of the granted requester
- zera  output  1  clear counter/register, one cycle
- conta  output  1  counter enable
- registra  output  1  latch register, one cycle
- pronto  output  1  transaction-done pulse, one cycle
- ocupado  output  1  high in every state except OCIOSO
- erro  output  1  timeout-abort pulse, coincident with pronto (tied 0 without macro)

## Operation

- States: OCIOSO, ZERA, CONTA, REGISTRA, FIM. Datapath outputs decode from state only (Moore).
- OCIOSO:
  - All outputs 0.
  - If req != 0, pick the winner, register grant/id_grant, go to ZERA; otherwise stay.
- ZERA: zera=1 → CONTA.
- CONTA:
  - conta=1.
  - fim_contador=1 → REGISTRA, else stay.
- REGISTRA: registra=1 → FIM.
- FIM:
  - pronto=1.
  - Update the priority pointer to id_grant.
  - Next state is OCIOSO.
  - grant is cleared on the transition out of FIM.
- grant and id_grant stay constant from ZERA through FIM.
- Arbitration:
  - Search req starting at index (ptr+1) mod N_REQ, ascending with wrap.
  - The first set bit wins.
- Reset value of ptr is N_REQ-1, so req[0] has top priority after reset.
- req changes after grant (drop or new bits) are ignored until the next OCIOSO evaluation. A dropped requester still gets its full transaction.
- fim_contador is ignored outside CONTA.
- Reset (reset=0 at a rising edge), in any state:
  - state=OCIOSO, ptr=N_REQ-1, timeout counter=0.
  - All outputs 0 on the next cycle.
  - An in-flight transaction is abandoned with no pronto.

## Timing

- req rising in cycle k, sampled in OCIOSO at edge k → ZERA during cycle k+1.
- Minimum transaction is 4 cycles (ZERA, CONTA, REGISTRA, FIM) with fim_contador=1 in the first CONTA cycle.
- CONTA lasts n cycles, where n is the cycle in which fim_contador is first seen high.
- Total busy time is n+3 cycles.
- One idle OCIOSO cycle always separates back-to-back transactions, so worst-case wait for a requester is (N_REQ-1)·(transaction+1) cycles.
- Outputs are valid from the clock edge that enters each state. No combinational path from inputs to outputs.

## Configuration

- Macro: ARBITRO_TIMEOUT_EN.
- Defined:
  - An 8-bit (or wider, ≥$clog2(TIMEOUT+1)) counter clears on entering CONTA and increments each CONTA cycle.
  - When it reaches TIMEOUT with fim_contador=0, go CONTA → FIM, skip REGISTRA (registra never pulses), and assert erro=1 with pronto in FIM.
  - If fim_contador=1 and the timeout hit in the same cycle, fim_contador wins: REGISTRA, erro=0.
- Undefined:
  - No counter; CONTA waits indefinitely.
  - erro is tied 0.
  - The TIMEOUT parameter is unused.

## Test plan

- Reset:
  - Hold reset=0 for 3 cycles with req=4'b1111 → all outputs 0, ocupado=0.
  - Release → first grant=4'b0001, id_grant=0.
- Single request:
  - req=4'b0100, fim_contador high on the 5th CONTA cycle.
  - Response: zera one cycle, conta 5 cycles, registra one cycle, pronto one cycle.
  - grant=4'b0100 throughout.
- Round robin:
  - req=4'b1111 held, fim_contador=1 always.
  - Grant order is 0,1,2,3,0; each transaction is 4 cycles with one OCIOSO cycle between.
- Mid-transaction changes:
  - req=4'b0010, then drop it and raise req[3] during CONTA.
  - Transaction 1 completes with grant=4'b0010, followed by grant=4'b1000.
- Reset mid-CONTA:
  - Apply reset=0 during CONTA → no pronto, grant=0 next cycle.
  - Priority returns to req[0].
- Timeout (macro defined, TIMEOUT=10):
  - With fim_contador=0 → 10 conta cycles, then pronto=1 and erro=1, registra never high.
  - Repeat with fim_contador=1 on cycle 10 → registra pulses, erro=0.
